// File: rtl/debug_cmd_sysclk_bridge.sv
// debug_cmd_sysclk_bridge
// System-clock side of the JTAG debug slave. It synchronises the update-IR and
// update-DR strobes from TCK, captures each IR/DR snapshot, and queues the
// commands in a small FIFO. The output register presents them to the consumer
// through a valid/ready handshake. Each accept raises a one-hot action strobe.
module debug_cmd_sysclk_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 34,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    input  logic                          vs_uir,
    input  logic                          vs_udr,
    input  logic                          cmd_ready,
    input  logic                          ovf_clr,
    output logic [DATA_W-1:0]             jdo,
    output logic [IR_W-1:0]               cmd_ir,
    output logic                          cmd_valid,
    output logic [(2**IR_W)-1:0]          take_action,
    output logic [(2**IR_W)-1:0]          take_no_action,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int ENT_W = IR_W + DATA_W;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_dly;
    logic                   udr_dly;
    logic                   uir_evt;
    logic                   udr_evt;

    logic [IR_W-1:0]        ir_q;

    // The pointers carry one bit more than the address. This lets a full queue be
    // told apart from an empty one.
    logic [ENT_W-1:0]       mem [FIFO_DEPTH];
    logic [LW-1:0]          wr_ptr;
    logic [LW-1:0]          rd_ptr;
    logic [ENT_W-1:0]       head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   push;
    logic                   ovf_evt;
    logic                   accept;

    // Synchronise both TCK-domain levels. The delay flops then detect their rising edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
            uir_dly  <= 1'b0;
            udr_dly  <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_dly  <= uir_sync[SYNC_STAGES-1];
            udr_dly  <= udr_sync[SYNC_STAGES-1];
        end
    end

    assign uir_evt = uir_sync[SYNC_STAGES-1] & ~uir_dly;
    assign udr_evt = udr_sync[SYNC_STAGES-1] & ~udr_dly;

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_level == DEPTH_L);
    assign fifo_empty = (fifo_level == '0);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign pop        = ~fifo_empty & (~cmd_valid | cmd_ready);
    assign push       = udr_evt & (~fifo_full | pop);
    assign ovf_evt    = udr_evt & fifo_full & ~pop;
    assign accept     = cmd_valid & cmd_ready;

    // Capture the instruction. A DR push in the same cycle still sees the old ir_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= '0;
        end else if (uir_evt) begin
            ir_q <= ir_in;
        end
    end

    // Queue storage. It holds no reset state because the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {ir_q, sr};
        end
    end

    // Advance the queue pointers and the sticky overflow flag. A drop in the same cycle as ovf_clr leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Output register. It refills from the queue head whenever it is free or being accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            jdo       <= '0;
            cmd_ir    <= '0;
        end else if (pop) begin
            cmd_valid     <= 1'b1;
            {cmd_ir, jdo} <= head;
        end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    // Decode the one-hot action strobes combinationally from the current accept.
    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (accept) begin
            if (jdo[ACT_BIT]) begin
                take_action[cmd_ir] = 1'b1;
            end else begin
                take_no_action[cmd_ir] = 1'b1;
            end
        end
    end

endmodule
